// File: rtl/sequencer.sv
// -----------------------------------------------------------------------------
// sequencer
//   Control-unit FSM for the basic processor. Walks fetch (F0..F2), decode (D0)
//   and execute (X1, X2, END), driving every sysbus enable and register-load
//   strobe. Memory cycles are stretched while mem_ready is low; an undefined
//   opcode parks the FSM in HALT until n_reset.
//
//   Opcode map (instruction word top OP_W bits):
//     LOAD = 0, STORE = 1, ADD = 2, SUB = 3, BNE = 4, anything else undefined.
//
// Ports
//   clock, n_reset   clock (rising edge) / async active-low reset
//   run              level; start / continue at instruction boundaries
//   op               opcode field from IR
//   z_flag           ACC == 0
//   mem_ready        memory access complete
//   PC_bus .. ALU_sub  bus enables and load strobes (registered, Moore)
//   halted           1 while parked in HALT
// -----------------------------------------------------------------------------
module sequencer #(
    parameter int OP_W = 3
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic            run,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            CS,
    output logic            R_NW,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            halted
);

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);

    // X1/X2 are split per instruction class so every strobe is a pure
    // function of the state register.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F0     = 4'd1,
        S_F1     = 4'd2,
        S_F2     = 4'd3,
        S_D0     = 4'd4,
        S_X1_RD  = 4'd5,   // operand / branch-pointer read
        S_X1_ST  = 4'd6,   // ACC -> MDR
        S_X1_NB  = 4'd7,   // BNE not taken, idle cycle
        S_X2_LD  = 4'd8,
        S_X2_ADD = 4'd9,
        S_X2_SUB = 4'd10,
        S_X2_ST  = 4'd11,
        S_X2_BR  = 4'd12,
        S_END    = 4'd13,
        S_HALT   = 4'd14
    } state_t;

    typedef struct packed {
        logic pc_bus;
        logic ld_pc;
        logic inc_pc;
        logic ld_ir;
        logic addr_bus;
        logic ld_mar;
        logic mdr_bus;
        logic ld_mdr;
        logic cs;
        logic r_nw;
        logic acc_bus;
        logic ld_acc;
        logic alu_acc;
        logic alu_add;
        logic alu_sub;
        logic halted;
    } strobe_t;

    state_t  state_q, state_d;
    strobe_t out_q;

    function automatic logic op_defined(logic [OP_W-1:0] o);
        return (o == OP_LOAD) || (o == OP_STORE) || (o == OP_ADD) ||
               (o == OP_SUB)  || (o == OP_BNE);
    endfunction

    function automatic strobe_t decode(state_t s);
        strobe_t o;
        o = '0;
        case (s)
            S_F0: begin
                o.pc_bus = 1'b1; o.ld_mar = 1'b1; o.ld_pc = 1'b1; o.inc_pc = 1'b1;
            end
            S_F1, S_X1_RD: begin
                o.cs = 1'b1; o.r_nw = 1'b1; o.ld_mdr = 1'b1;
            end
            S_F2:     begin o.mdr_bus  = 1'b1; o.ld_ir  = 1'b1; end
            S_D0:     begin o.addr_bus = 1'b1; o.ld_mar = 1'b1; end
            S_X1_ST:  begin o.acc_bus  = 1'b1; o.ld_mdr = 1'b1; end
            S_X2_LD:  begin o.mdr_bus = 1'b1; o.alu_acc = 1'b1; o.ld_acc = 1'b1; end
            S_X2_ADD: begin o.mdr_bus = 1'b1; o.alu_add = 1'b1; o.ld_acc = 1'b1; end
            S_X2_SUB: begin o.mdr_bus = 1'b1; o.alu_sub = 1'b1; o.ld_acc = 1'b1; end
            S_X2_ST:  o.cs = 1'b1;                 // write: R_NW stays 0
            S_X2_BR:  begin o.mdr_bus = 1'b1; o.ld_pc = 1'b1; end
            S_HALT:   o.halted = 1'b1;
            default:  ;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = run ? S_F0 : S_IDLE;
            S_F0:   state_d = S_F1;
            S_F1:   state_d = mem_ready ? S_F2 : S_F1;
            S_F2:   state_d = S_D0;
            // Instruction class and branch condition are resolved here so the
            // X1 strobes never depend on live inputs; ACC (hence z_flag) is
            // stable from the previous instruction's X2 through this X1.
            S_D0: begin
                if (!op_defined(op))   state_d = S_HALT;
                else if (op == OP_STORE) state_d = S_X1_ST;
                else if (op == OP_BNE && z_flag) state_d = S_X1_NB;
                else                    state_d = S_X1_RD;
            end
            S_X1_RD: begin
                if (mem_ready) begin
                    case (op)
                        OP_LOAD: state_d = S_X2_LD;
                        OP_ADD:  state_d = S_X2_ADD;
                        OP_SUB:  state_d = S_X2_SUB;
                        OP_BNE:  state_d = S_X2_BR;
                        default: state_d = S_HALT;
                    endcase
                end
            end
            S_X1_ST:  state_d = S_X2_ST;
            S_X1_NB:  state_d = S_END;
            S_X2_ST:  state_d = mem_ready ? S_END : S_X2_ST;
            S_X2_LD, S_X2_ADD, S_X2_SUB, S_X2_BR: state_d = S_END;
            S_END:    state_d = run ? S_F0 : S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered as the decode of the next state, so they always
    // equal decode(state_q) with no input-to-output path.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= decode(state_d);
        end
    end

    assign PC_bus   = out_q.pc_bus;
    assign load_PC  = out_q.ld_pc;
    assign INC_PC   = out_q.inc_pc;
    assign load_IR  = out_q.ld_ir;
    assign Addr_bus = out_q.addr_bus;
    assign load_MAR = out_q.ld_mar;
    assign MDR_bus  = out_q.mdr_bus;
    assign load_MDR = out_q.ld_mdr;
    assign CS       = out_q.cs;
    assign R_NW     = out_q.r_nw;
    assign ACC_bus  = out_q.acc_bus;
    assign load_ACC = out_q.ld_acc;
    assign ALU_ACC  = out_q.alu_acc;
    assign ALU_add  = out_q.alu_add;
    assign ALU_sub  = out_q.alu_sub;
    assign halted   = out_q.halted;

endmodule

// File: tb/tb_sequencer.sv
module tb_sequencer;

  localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_ADD = 3'd2,
                         OP_SUB = 3'd3, OP_BNE = 3'd4;

  // strobe vector bit positions
  localparam logic [15:0] B_PCBUS = 16'h8000, B_LDPC  = 16'h4000, B_INC   = 16'h2000,
                          B_LDIR  = 16'h1000, B_ADDR  = 16'h0800, B_LDMAR = 16'h0400,
                          B_MDRB  = 16'h0200, B_LDMDR = 16'h0100, B_CS    = 16'h0080,
                          B_RNW   = 16'h0040, B_ACCB  = 16'h0020, B_LDACC = 16'h0010,
                          B_AACC  = 16'h0008, B_AADD  = 16'h0004, B_ASUB  = 16'h0002,
                          B_HALT  = 16'h0001;

  localparam logic [15:0] V_NONE = 16'h0000;
  localparam logic [15:0] V_F0   = B_PCBUS | B_LDMAR | B_LDPC | B_INC;
  localparam logic [15:0] V_RD   = B_CS | B_RNW | B_LDMDR;
  localparam logic [15:0] V_F2   = B_MDRB | B_LDIR;
  localparam logic [15:0] V_D0   = B_ADDR | B_LDMAR;
  localparam logic [15:0] V_X1ST = B_ACCB | B_LDMDR;
  localparam logic [15:0] V_X2LD = B_MDRB | B_AACC | B_LDACC;
  localparam logic [15:0] V_X2AD = B_MDRB | B_AADD | B_LDACC;
  localparam logic [15:0] V_X2SB = B_MDRB | B_ASUB | B_LDACC;
  localparam logic [15:0] V_X2ST = B_CS;
  localparam logic [15:0] V_X2BR = B_MDRB | B_LDPC;
  localparam logic [15:0] V_HALT = B_HALT;

  logic clock = 1'b0, n_reset = 1'b0, run_r = 1'b0, z_r = 1'b0, mr_r = 1'b1, prog = 1'b0;
  logic [2:0] op_r = 3'd0;
  logic [2:0] op;
  logic z_flag, mem_ready;
  logic PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, MDR_bus, load_MDR;
  logic CS, R_NW, ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, halted;

  // tiny datapath + unified ROM/RAM for the program run
  logic [7:0] mem [32];
  logic [7:0] ir, mdr, acc, bus;
  logic [4:0] pc, mar;
  logic [7:0] disp_q[$];

  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_q[$];
  bit mr_q[$];

  assign op        = prog ? ir[7:5] : op_r;
  assign z_flag    = prog ? (acc == 8'd0) : z_r;
  assign mem_ready = prog ? 1'b1 : mr_r;

  always #5 clock = ~clock;

  sequencer #(.OP_W(3)) dut (
    .clock(clock), .n_reset(n_reset), .run(run_r), .op(op), .z_flag(z_flag),
    .mem_ready(mem_ready), .PC_bus(PC_bus), .load_PC(load_PC), .INC_PC(INC_PC),
    .load_IR(load_IR), .Addr_bus(Addr_bus), .load_MAR(load_MAR), .MDR_bus(MDR_bus),
    .load_MDR(load_MDR), .CS(CS), .R_NW(R_NW), .ACC_bus(ACC_bus), .load_ACC(load_ACC),
    .ALU_ACC(ALU_ACC), .ALU_add(ALU_add), .ALU_sub(ALU_sub), .halted(halted)
  );

  function automatic logic [7:0] rom(int a);
    case (a)
      0: return {OP_LOAD, 5'd20};   // ACC = 0
      1: return {OP_ADD, 5'd21};    // ACC += 1
      2: return {OP_STORE, 5'd23};  // disp = ACC
      3: return {OP_SUB, 5'd22};    // ACC -= 9
      4: return {OP_BNE, 5'd24};    // not 9 yet -> 7
      5: return {OP_LOAD, 5'd21};   // ACC = 1 so the jump below is taken
      6: return {OP_BNE, 5'd25};    // -> 0
      7: return {OP_LOAD, 5'd23};   // restore count
      8: return {OP_BNE, 5'd26};    // -> 1
      20: return 8'd0;
      21: return 8'd1;
      22: return 8'd9;
      24: return 8'd7;
      26: return 8'd1;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    bus = 8'd0;
    if (PC_bus)   bus = {3'd0, pc};
    if (Addr_bus) bus = {3'd0, ir[4:0]};
    if (MDR_bus)  bus = mdr;
    if (ACC_bus)  bus = acc;
  end

  always @(posedge clock) begin
    if (!prog) begin
      pc <= 5'd0; mar <= 5'd0; ir <= 8'd0; mdr <= 8'd0; acc <= 8'd0;
      for (int i = 0; i < 32; i++) mem[i] <= rom(i);
    end else begin
      if (load_PC)  pc  <= INC_PC ? pc + 5'd1 : bus[4:0];
      if (load_MAR) mar <= bus[4:0];
      if (load_IR)  ir  <= bus;
      if (load_MDR) mdr <= (CS && R_NW) ? mem[mar] : bus;
      if (CS && !R_NW) begin
        mem[mar] <= mdr;
        if (mar == 5'd23) disp_q.push_back(mdr);
      end
      if (load_ACC) acc <= ALU_ACC ? bus : ALU_add ? acc + bus : ALU_sub ? acc - bus : acc;
    end
  end

  function automatic logic [15:0] vec();
    return {PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, MDR_bus, load_MDR,
            CS, R_NW, ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, halted};
  endfunction

  task automatic chk(string tag, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // one clock, sampled at the falling edge, with the per-cycle bus invariants
  task automatic tick();
    @(negedge clock);
    chk("bus_excl", 16'($countones({PC_bus, Addr_bus, MDR_bus, ACC_bus}) <= 1), 16'd1);
    chk("cs_wr_mdr", 16'(CS && !R_NW && load_MDR), 16'd0);
  endtask

  task automatic push(logic [15:0] v, bit mr);
    exp_q.push_back(v);
    mr_q.push_back(mr);
  endtask

  // memory phase: n not-ready cycles then one ready cycle, same strobes
  task automatic push_mem(logic [15:0] v, int n);
    repeat (n) push(v, 1'b0);
    push(v, 1'b1);
  endtask

  // expected per-cycle strobe trace of one instruction, F0 through END
  task automatic plan(logic [2:0] o, logic z, int s1, int sx1, int sx2);
    push(V_F0, 1'($urandom));
    push_mem(V_RD, s1);
    push(V_F2, 1'($urandom));
    push(V_D0, 1'($urandom));
    case (o)
      OP_LOAD:  begin push_mem(V_RD, sx1); push(V_X2LD, 1'($urandom)); end
      OP_ADD:   begin push_mem(V_RD, sx1); push(V_X2AD, 1'($urandom)); end
      OP_SUB:   begin push_mem(V_RD, sx1); push(V_X2SB, 1'($urandom)); end
      OP_STORE: begin push(V_X1ST, 1'($urandom)); push_mem(V_X2ST, sx2); end
      OP_BNE:   if (z) push(V_NONE, 1'($urandom));
                else begin push_mem(V_RD, sx1); push(V_X2BR, 1'($urandom)); end
      default:  push(V_HALT, 1'($urandom));
    endcase
    if (o <= OP_BNE) push(V_NONE, 1'($urandom));  // END
  endtask

  // caller leaves run=1 with the FSM in IDLE or END
  task automatic run_instr(logic [2:0] o, logic z, int s1, int sx1, int sx2, bit last);
    logic [15:0] v;
    plan(o, z, s1, sx1, sx2);
    op_r = o;
    z_r  = z;
    while (exp_q.size() != 0) begin
      v = exp_q.pop_front();
      tick();
      chk("trace", vec(), v);
      mr_r = mr_q.pop_front();
      if (exp_q.size() == 0) run_r = !last;
    end
  endtask

  task automatic reset_pulse(bit run_after);
    #2 n_reset = 1'b0;
    #1 chk("async_rst", vec(), V_NONE);
    run_r = run_after;
    #1 n_reset = 1'b1;
  endtask

  initial begin
    logic [2:0] o;
    int r;
    int n_rand = 60;

    // reset state
    repeat (2) tick();
    chk("in_reset", vec(), V_NONE);
    n_reset = 1'b1;
    tick();
    chk("idle", vec(), V_NONE);

    // async reset in the middle of LOAD X2
    op_r = OP_LOAD; mr_r = 1'b1; run_r = 1'b1;
    repeat (6) tick();
    chk("x2_load", vec(), V_X2LD);
    reset_pulse(1'b0);
    repeat (3) begin
      tick();
      chk("idle_run0", vec(), V_NONE);
    end

    // directed: LOAD, BNE taken, BNE untaken, STORE with 3 write stalls, stop
    run_r = 1'b1;
    run_instr(OP_LOAD,  1'b0, 0, 0, 0, 1'b0);
    run_instr(OP_BNE,   1'b0, 0, 0, 0, 1'b0);
    run_instr(OP_BNE,   1'b1, 0, 0, 0, 1'b0);
    run_instr(OP_STORE, 1'b0, 0, 0, 3, 1'b1);
    tick();
    chk("stop_at_end", vec(), V_NONE);

    // random instruction stream; first one is the undefined opcode 7
    run_r = 1'b1;
    for (int i = 0; i < n_rand; i++) begin
      r = int'($urandom_range(0, 15));
      o = (i == 0) ? 3'd7 : (r < 14) ? 3'(r % 5) : 3'(5 + r % 3);
      run_instr(o, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), i == n_rand - 1);
      if (o > OP_BNE) begin
        repeat (20) begin
          run_r = 1'($urandom);
          tick();
          chk("halt_hold", vec(), V_HALT);
        end
        reset_pulse(i != n_rand - 1);
      end
    end
    tick();
    chk("idle_final", vec(), V_NONE);

    // count program on the datapath model
    reset_pulse(1'b0);
    tick();
    prog = 1'b1;
    run_r = 1'b1;
    repeat (1500) tick();
    chk("disp_writes", 16'(disp_q.size() >= 18), 16'd1);
    for (int i = 0; i < disp_q.size(); i++)
      chk("disp_seq", 16'(disp_q[i]), 16'((i % 9) + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
